// File: rtl/mul_tail.sv
// mul_tail: elastic multiplier writeback tail (pipeline stages M2..M5).
// Carries M1 results toward writeback and collapses bubbles under
// writeback back-pressure. Each stage holds its own valid bit. Decode can
// query whether a register write is still pending in the tail.
module mul_tail #(
  parameter int REG_SIZE = 32,
  parameter int REG_ADDR = 5,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [REG_ADDR-1:0] in_dst,
  input  logic [REG_SIZE-1:0] in_result,
  input  logic                in_overflow,
  input  logic                in_zero,
  output logic                in_ready,
  input  logic                flush,
  input  logic                wb_ready,
  output logic                out_valid,
  output logic [REG_ADDR-1:0] out_dst,
  output logic [REG_SIZE-1:0] out_result,
  output logic                out_overflow,
  output logic                out_zero,
  input  logic [REG_ADDR-1:0] rs_a,
  input  logic [REG_ADDR-1:0] rs_b,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic [2:0]          pending_count
);

  logic [DEPTH-1:0]    s_valid;
  logic [REG_ADDR-1:0] s_dst      [DEPTH];
  logic [REG_SIZE-1:0] s_result   [DEPTH];
  logic [DEPTH-1:0]    s_overflow;
  logic [DEPTH-1:0]    s_zero;
  logic [DEPTH-1:0]    adv;

  // Advance enables: stage k may move forward when wb consumes this cycle
  // or any stage above k (including the last) is empty. This is the
  // unrolled form of adv[k] = !s[k+1].valid || adv[k+1].
  always_comb begin
    logic all_full;
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      all_full = s_valid[DEPTH-1];
      for (int j = k + 1; j < DEPTH; j++) begin
        all_full = all_full & s_valid[j];
      end
      adv[k] = wb_ready || !all_full;
    end
  end

  assign in_ready = !s_valid[0] || adv[0];

  // Stage registers: reset/flush clear everything, otherwise shift where enabled.
  // Bubbles carry zero data so idle stages never show stale results.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s_valid    <= '0;
      s_overflow <= '0;
      s_zero     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        s_dst[k]    <= '0;
        s_result[k] <= '0;
      end
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (adv[k-1]) begin
          s_valid[k]    <= s_valid[k-1];
          s_dst[k]      <= s_dst[k-1];
          s_result[k]   <= s_result[k-1];
          s_overflow[k] <= s_overflow[k-1];
          s_zero[k]     <= s_zero[k-1];
        end
      end
      if (in_ready) begin
        s_valid[0]    <= in_valid;
        s_dst[0]      <= in_valid ? in_dst : '0;
        s_result[0]   <= in_valid ? in_result : '0;
        s_overflow[0] <= in_valid && in_overflow;
        s_zero[0]     <= in_valid && in_zero;
      end
    end
  end

  assign out_valid    = s_valid[DEPTH-1];
  assign out_dst      = s_dst[DEPTH-1];
  assign out_result   = s_result[DEPTH-1];
  assign out_overflow = s_overflow[DEPTH-1];
  assign out_zero     = s_zero[DEPTH-1];

  // Occupancy and hazard scan over all stages; register 0 is never a hazard.
  always_comb begin
    pending_count = '0;
    hazard_a      = 1'b0;
    hazard_b      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pending_count = pending_count + 3'(s_valid[k]);
      if (s_valid[k] && (rs_a != '0) && (s_dst[k] == rs_a)) hazard_a = 1'b1;
      if (s_valid[k] && (rs_b != '0) && (s_dst[k] == rs_b)) hazard_b = 1'b1;
    end
  end

endmodule

// File: doc/mul_tail.md
MUL_TAIL -- requirements
Module: mul_tail

Interface
REQ-001 Parameter REG_SIZE, default 32, data width of multiplier result.
REQ-002 Parameter REG_ADDR, default 5, register-address width.
REQ-003 Parameter DEPTH, default 4, number of tail stages (M2..M5); legal range 2..7.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 in_valid  input  1  M1 result valid (M1 regwrite_out).
REQ-007 in_dst  input  REG_ADDR  destination register from M1.
REQ-008 in_result  input  REG_SIZE  low product word from M1.
REQ-009 in_overflow  input  1  overflow flag from M1.
REQ-010 in_zero  input  1  zero flag from M1.
REQ-011 in_ready  output  1  tail can accept an entry this cycle.
REQ-012 flush  input  1  kill all in-flight entries.
REQ-013 wb_ready  input  1  writeback consumes output entry this cycle.
REQ-014 out_valid, out_dst, out_result, out_overflow, out_zero  output  1/REG_ADDR/REG_SIZE/1/1  entry in last stage.
REQ-015 rs_a, rs_b  input  REG_ADDR  decode-stage source registers for hazard query.
REQ-016 hazard_a, hazard_b  output  1  pending write to rs_a / rs_b.
REQ-017 pending_count  output  3  number of valid entries in tail.

Function
REQ-018 Tail SHALL hold DEPTH stage registers s[0..DEPTH-1], each {valid, dst, result, overflow, zero}; s[DEPTH-1] drives out_* directly.
REQ-019 Handshake: output transfer occurs at an edge where out_valid && wb_ready; input transfer occurs where in_valid && in_ready.
REQ-020 Stage k advance condition adv[k]: s[k+1] empty or adv[k+1]; adv[DEPTH-1] = !out_valid || wb_ready.
REQ-021 in_ready SHALL be combinational = !s[0].valid || adv[0].
REQ-022 On adv[k], s[k+1] loads s[k]; s[k] with valid set that does not advance holds all fields (bubbles collapse, no entry lost or duplicated).
REQ-023 Unstalled latency: entry accepted at edge N appears with out_valid high after edge N+DEPTH-1 (DEPTH cycles in tail); throughput one entry per cycle.
REQ-024 Stall: while out_valid && !wb_ready, s[DEPTH-1] SHALL hold stable; upstream stages keep filling until full; in_ready low only when all stages valid and wb_ready low.
REQ-025 in_valid while in_ready low SHALL be ignored (upstream holds).
REQ-026 Data fields pass through unmodified; no arithmetic in tail.
REQ-027 hazard_x SHALL be combinational: rs_x != 0 and some valid s[k] has dst == rs_x; entries with dst 0 never raise hazard.
REQ-028 Entries with dst 0 SHALL still flow and present out_valid.
REQ-029 pending_count = popcount of stage valid bits, 0..DEPTH.
REQ-030 flush: at the edge, all valid bits cleared; input presented that cycle discarded; an output transfer completing at that edge counts as delivered.
REQ-031 Simultaneous output transfer and input transfer at a full tail SHALL be accepted (pass-through full throughput).

Reset
REQ-032 reset SHALL clear all valid bits and zero all stage data fields; out_valid, out_*, hazard_a/b, pending_count read 0 the cycle after.
REQ-033 reset SHALL take priority over flush, input and output transfers; in_ready is 1 after reset.
REQ-034 reset mid-operation discards all in-flight entries; none reach out_valid.

Verification
REQ-035 Single entry: in_valid, dst=5, result=0x0000_0030, wb_ready=1 -> out_valid with dst 5, result 0x30 exactly 4 cycles later, pending_count 1,2.. back to 0.
REQ-036 Back-to-back 8 entries, wb_ready=1 -> in_ready always 1, outputs in order, one per cycle, no gaps.
REQ-037 wb_ready=0 with 6 entries offered -> tail fills to 4, in_ready drops after 4th, out_* stable; wb_ready=1 -> remaining drain in order, none lost.
REQ-038 Hazard: entry dst=7 in flight, rs_a=7, rs_b=0 -> hazard_a=1 until output transfer, hazard_b=0; entry dst=0 with rs_a=0 -> hazard_a=0.
REQ-039 flush with 3 entries and in_valid high -> next cycle pending_count 0, out_valid 0; flushed dsts never appear.
REQ-040 reset asserted with full stalled tail -> next cycle all outputs 0, in_ready 1; new entry after reset emerges after 4 cycles.
